// File: rtl/input_conditioner_if.sv
// Cabinet button bus: raw active-low pins in, formatted port bytes and status out.
interface input_conditioner_if;
  logic [5:0] btn_raw;
  logic [7:0] buttons_a;
  logic [7:0] buttons_b;
  logic [7:0] coin_count;
  logic       ms_tick;

  // Conditioner side: consumes raw pins, produces the port bytes.
  modport master (
    input  btn_raw,
    output buttons_a,
    output buttons_b,
    output coin_count,
    output ms_tick
  );

  // Consumer side: drives the pins, reads the port bytes.
  modport slave (
    output btn_raw,
    input  buttons_a,
    input  buttons_b,
    input  coin_count,
    input  ms_tick
  );
endinterface

// File: rtl/input_conditioner.sv
// Cabinet input conditioner: synchronise, debounce, block opposing joystick
// directions, shape coin presses into fixed pulses, and format IN0/IN1 bytes.
module input_conditioner #(
  parameter int CLK_HZ        = 33330000,
  parameter int DEBOUNCE_MS   = 10,
  parameter int COIN_PULSE_MS = 100
) (
  input  logic                  clk_pixel,
  input  logic                  reset_n,
  input_conditioner_if.master   bus
);

  localparam int TICK_N = CLK_HZ / 1000;
  localparam int TICK_W = (TICK_N > 1) ? $clog2(TICK_N) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_N - 1);
  localparam logic [7:0] DEB_LAST  = 8'(DEBOUNCE_MS - 1);
  localparam logic [7:0] PULSE_LEN = 8'(COIN_PULSE_MS);

  typedef enum logic [1:0] {IDLE, PULSE, WAIT_REL} coin_state_t;

  // Saturating coin counter increment; sticks at 255.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [5:0]        sync_p0;
  logic [5:0]        sync_p1;
  logic [5:0]        sync_pressed;
  logic [TICK_W-1:0] tick_cnt;
  logic              ms_tick_q;
  logic [5:0]        deb;
  logic [7:0]        deb_cnt [6];
  logic              up_eff, down_eff, left_eff, right_eff;
  coin_state_t       state, state_nxt;
  logic [7:0]        pcnt, pcnt_nxt;
  logic [7:0]        coin_cnt, coin_cnt_nxt;
  logic              coin_pulse;
  logic [7:0]        buttons_a_p2;
  logic [7:0]        buttons_b_p2;

  // Stage p0/p1: two-flop synchroniser on the raw active-low pins.
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      sync_p0 <= '1;
      sync_p1 <= '1;
    end else begin
      sync_p0 <= bus.btn_raw;
      sync_p1 <= sync_p0;
    end
  end

  assign sync_pressed = ~sync_p1;

  // Free-running 1 ms divider; strobe marks the cycle the counter wraps to 0.
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt  <= '0;
      ms_tick_q <= 1'b0;
    end else if (tick_cnt == TICK_LAST) begin
      tick_cnt  <= '0;
      ms_tick_q <= 1'b1;
    end else begin
      tick_cnt  <= tick_cnt + 1'b1;
      ms_tick_q <= 1'b0;
    end
  end

  // Per-bit debounce: a differing level must persist for DEBOUNCE_MS ticks.
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      deb <= '0;
      for (int i = 0; i < 6; i++) deb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 6; i++) begin
        if (sync_pressed[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (ms_tick_q) begin
          if (deb_cnt[i] == DEB_LAST) begin
            deb[i]     <= sync_pressed[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + 8'd1;
          end
        end
      end
    end
  end

  // Opposing joystick directions cancel each other out.
  assign up_eff    = deb[0] & ~deb[1];
  assign down_eff  = deb[1] & ~deb[0];
  assign left_eff  = deb[2] & ~deb[3];
  assign right_eff = deb[3] & ~deb[2];

  // Coin FSM state, pulse length counter and coin counter registers.
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      pcnt     <= '0;
      coin_cnt <= '0;
    end else begin
      state    <= state_nxt;
      pcnt     <= pcnt_nxt;
      coin_cnt <= coin_cnt_nxt;
    end
  end

  // Coin FSM next state: one fixed-length pulse per debounced press.
  always_comb begin
    state_nxt    = state;
    pcnt_nxt     = pcnt;
    coin_cnt_nxt = coin_cnt;
    coin_pulse   = 1'b0;
    case (state)
      IDLE: begin
        if (deb[4]) begin
          state_nxt    = PULSE;
          pcnt_nxt     = PULSE_LEN;
          coin_cnt_nxt = sat_inc(coin_cnt);
        end
      end
      PULSE: begin
        coin_pulse = 1'b1;
        if (ms_tick_q) begin
          pcnt_nxt = pcnt - 8'd1;
          if (pcnt <= 8'd1) begin
            state_nxt = WAIT_REL;
            pcnt_nxt  = '0;
          end
        end
      end
      WAIT_REL: begin
        if (!deb[4]) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p2: registered active-low port bytes.
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      buttons_a_p2 <= 8'hFF;
      buttons_b_p2 <= 8'hFF;
    end else begin
      buttons_a_p2 <= {2'b11, ~coin_pulse, 1'b1, ~down_eff, ~right_eff, ~left_eff, ~up_eff};
      buttons_b_p2 <= {2'b11, ~deb[5], 5'b11111};
    end
  end

  assign bus.buttons_a  = buttons_a_p2;
  assign bus.buttons_b  = buttons_b_p2;
  assign bus.coin_count = coin_cnt;
  assign bus.ms_tick    = ms_tick_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner with a tick-counting reference model.
module tb_input_conditioner;
  localparam int CLK_HZ   = 10000;
  localparam int DEB      = 3;
  localparam int PULSE    = 5;
  localparam int TICK_CYC = CLK_HZ / 1000;

  localparam logic [5:0] B_UP    = 6'b000001;
  localparam logic [5:0] B_DOWN  = 6'b000010;
  localparam logic [5:0] B_COIN  = 6'b010000;
  localparam logic [5:0] B_START = 6'b100000;

  logic clk_pixel = 1'b0;
  logic reset_n   = 1'b1;

  input_conditioner_if bus();

  input_conditioner #(
    .CLK_HZ(CLK_HZ),
    .DEBOUNCE_MS(DEB),
    .COIN_PULSE_MS(PULSE)
  ) dut (
    .clk_pixel(clk_pixel),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk_pixel = ~clk_pixel;

  int checks = 0;
  int errors = 0;
  int edge_n;

  always @(posedge clk_pixel or negedge reset_n)
    if (!reset_n) edge_n <= 0;
    else          edge_n <= edge_n + 1;

  typedef struct {
    int          stamp;
    logic [23:0] val;
  } exp_t;

  exp_t        sb[$];
  bit          mon_en = 1'b0;
  logic [23:0] mon_last;

  // Reference model state (pressed = 1).
  logic [5:0]  m_deb;
  int          m_mis [6];
  bit          m_pulsing, m_waiting;
  int          m_pstart;
  int          m_count;
  logic [23:0] m_last;
  logic [5:0]  r_km1, r_k;

  // Number of ms ticks seen by edges following cycles a..b.
  function automatic int ticks_in(input int a, input int b);
    int lo;
    lo = (a < 1) ? 1 : a;
    return (b / TICK_CYC) - ((lo - 1) / TICK_CYC);
  endfunction

  task automatic model_reset();
    m_deb     = '0;
    for (int i = 0; i < 6; i++) m_mis[i] = -1;
    m_pulsing = 1'b0;
    m_waiting = 1'b0;
    m_pstart  = 0;
    m_count   = 0;
    m_last    = 24'hFFFF00;
    r_km1     = 6'h3F;
    r_k       = 6'h3F;
    sb.delete();
  endtask

  // Predict outputs after edge k+1 from the model state after edge k.
  task automatic model_step(input int k);
    logic [5:0]  sync, deb_n;
    logic [7:0]  ea, eb;
    logic [23:0] val;
    bit          tick, up, dn, lf, rt;
    sync = ~r_km1;
    tick = (k >= TICK_CYC) && (k % TICK_CYC == 0);
    up = m_deb[0] && !m_deb[1];
    dn = m_deb[1] && !m_deb[0];
    lf = m_deb[2] && !m_deb[3];
    rt = m_deb[3] && !m_deb[2];
    ea = {2'b11, ~m_pulsing, 1'b1, ~dn, ~rt, ~lf, ~up};
    eb = {2'b11, ~m_deb[5], 5'b11111};
    if (m_pulsing) begin
      if (tick && ticks_in(m_pstart, k) == PULSE) begin
        m_pulsing = 1'b0;
        m_waiting = 1'b1;
      end
    end else if (m_waiting) begin
      if (!m_deb[4]) m_waiting = 1'b0;
    end else if (m_deb[4]) begin
      m_pulsing = 1'b1;
      m_pstart  = k + 1;
      if (m_count < 255) m_count++;
    end
    deb_n = m_deb;
    for (int i = 0; i < 6; i++) begin
      if (sync[i] == m_deb[i]) begin
        m_mis[i] = -1;
      end else begin
        if (m_mis[i] < 0) m_mis[i] = k;
        if (ticks_in(m_mis[i], k) >= DEB) begin
          deb_n[i] = sync[i];
          m_mis[i] = -1;
        end
      end
    end
    m_deb = deb_n;
    val = {ea, eb, 8'(m_count)};
    if (val != m_last) sb.push_back('{k + 1, val});
    m_last = val;
  endtask

  // Hold a pressed-button mask for n cycles; called at a falling edge.
  task automatic drive(input logic [5:0] pressed, input int n);
    repeat (n) begin
      bus.btn_raw = ~pressed;
      model_step(edge_n);
      r_km1 = r_k;
      r_k   = ~pressed;
      @(negedge clk_pixel);
    end
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: pops an expectation whenever the DUT's outputs change.
  initial begin
    exp_t        e;
    logic [23:0] cur;
    bit          tk;
    forever begin
      @(posedge clk_pixel);
      #1;
      if (mon_en) begin
        tk = (edge_n >= TICK_CYC) && (edge_n % TICK_CYC == 0);
        checks++;
        if (bus.ms_tick !== tk) begin
          errors++;
          $display("FAIL ms_tick cycle=%0d actual=%b required=%b", edge_n, bus.ms_tick, tk);
        end
        cur = {bus.buttons_a, bus.buttons_b, bus.coin_count};
        if (cur !== mon_last) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_change cycle=%0d actual=%h required=%h", edge_n, cur, mon_last);
          end else begin
            e = sb.pop_front();
            if (e.val !== cur || e.stamp != edge_n) begin
              errors++;
              $display("FAIL scoreboard cycle=%0d actual=%h required=%h at cycle %0d",
                       edge_n, cur, e.val, e.stamp);
            end
          end
          mon_last = cur;
        end else if (sb.size() > 0 && sb[0].stamp < edge_n) begin
          checks++;
          errors++;
          e = sb.pop_front();
          $display("FAIL missed_change cycle=%0d actual=%h required=%h at cycle %0d",
                   edge_n, cur, e.val, e.stamp);
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    bus.btn_raw = '1;
    model_reset();
    #1 reset_n = 1'b0;
    #1;
    chk("reset_a", bus.buttons_a, 8'hFF);
    chk("reset_b", bus.buttons_b, 8'hFF);
    chk("reset_count", bus.coin_count, 8'h00);
    repeat (3) @(negedge clk_pixel);
    mon_last = 24'hFFFF00;
    reset_n  = 1'b1;
    mon_en   = 1'b1;

    // Debounce and glitch rejection on up.
    drive(B_UP, 60);             chk("up_press", bus.buttons_a, 8'hFE);
    drive(6'h00, 60);            chk("up_release", bus.buttons_a, 8'hFF);
    drive(B_UP, 20);
    drive(6'h00, 40);            chk("up_glitch", bus.buttons_a, 8'hFF);
    drive(B_UP, 20);
    drive(6'h00, 1);
    drive(B_UP, 60);             chk("up_restart", bus.buttons_a, 8'hFE);
    drive(6'h00, 60);

    // Opposing pair.
    drive(B_UP | B_DOWN, 60);    chk("up_down_both", bus.buttons_a, 8'hFF);
    drive(B_UP, 60);             chk("down_released", bus.buttons_a, 8'hFE);
    drive(6'h00, 60);

    // Coin pulse shaping.
    drive(B_COIN, 500);          chk("coin_hold_count", bus.coin_count, 8'd1);
                                 chk("coin_hold_port", bus.buttons_a, 8'hFF);
    drive(6'h00, 60);
    drive(B_COIN, 100);          chk("coin_second", bus.coin_count, 8'd2);
    drive(6'h00, 100);
    drive(B_COIN, 35);
    drive(6'h00, 100);           chk("coin_tap", bus.coin_count, 8'd3);
                                 chk("coin_tap_port", bus.buttons_a, 8'hFF);

    // Random button activity.
    for (int s = 0; s < 40; s++)
      drive(6'($urandom_range(0, 63)), int'($urandom_range(1, 60)));
    drive(6'h00, 150);

    // Reset in the middle of a coin pulse.
    drive(B_COIN, 45);           chk("pulse_before_reset", bus.buttons_a & 8'h20, 8'h00);
    mon_en = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("midreset_a", bus.buttons_a, 8'hFF);
    chk("midreset_b", bus.buttons_b, 8'hFF);
    chk("midreset_count", bus.coin_count, 8'h00);
    bus.btn_raw = '1;
    repeat (2) @(negedge clk_pixel);
    model_reset();
    mon_last = 24'hFFFF00;
    reset_n  = 1'b1;
    mon_en   = 1'b1;

    // Coin counter saturation.
    for (int p = 0; p < 257; p++) begin
      drive(B_COIN, 40);
      drive(6'h00, 70);
    end
    chk("coin_saturate", bus.coin_count, 8'd255);

    // Start button.
    drive(B_START, 60);          chk("start_press", bus.buttons_b, 8'hDF);
    drive(6'h00, 60);            chk("start_release", bus.buttons_b, 8'hFF);

    drive(6'h00, 20);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
    end
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
- Conditions the raw cabinet buttons (up/down/left/right/coin/start) before the CPU port mux at 0x5000/0x5040.
- Synchronises each input, debounces it, blocks impossible joystick combinations, and converts a coin press into a fixed-length coin pulse.
- Outputs the fully formatted active-low IN0/IN1 port bytes and a saturating coin counter for the LEDs.
- Runs on clk_pixel alongside the timing generator.

Parameters:
- CLK_HZ, 33330000, clk_pixel frequency in Hz; sets the 1 ms tick period (CLK_HZ/1000 cycles).
- DEBOUNCE_MS, 10, number of consecutive ms ticks of a changed level needed before a debounced state flips; range 1..255.
- COIN_PULSE_MS, 100, coin assertion length in ms ticks; range 1..255.

Ports:
- clk_pixel  in  1  pixel/system clock
- reset_n  in  1  asynchronous, active-low reset
- btn_raw  in  6  raw pins, active-low, {start, coin, right, left, down, up}
- buttons_a  out  8  IN0 byte {2'b11, coin_n, 1'b1, down_n, right_n, left_n, up_n}; registered
- buttons_b  out  8  IN1 byte {2'b11, start_n, 5'b11111}; registered
- coin_count  out  8  coin pulses issued since reset; saturates at 255
- ms_tick  out  1  single-cycle 1 ms strobe, exported for other blocks

Behaviour:
- Reset is asynchronous. While reset_n is low, all state takes its reset value:
  - sync flops = 1 (released)
  - debounced states = released
  - debounce counters, tick counter and coin_count = 0
  - coin FSM = IDLE
  - buttons_a = buttons_b = 8'hFF
  - ms_tick = 0
- Synchroniser: two flops per bit; sync_pressed[i] = ~btn_raw after the second flop.
- Tick:
  - The counter runs 0..CLK_HZ/1000-1.
  - ms_tick is high for the one cycle in which the counter wraps to 0. The first tick occurs CLK_HZ/1000 cycles after reset release.
- Debounce, per bit i:
  - If sync_pressed[i] == deb[i], cnt[i] clears to 0 immediately, in any cycle, tick or not.
  - Otherwise cnt[i] increments on each ms_tick.
  - On the tick where cnt[i] would reach DEBOUNCE_MS, deb[i] <= sync_pressed[i] and cnt[i] <= 0.
  - A glitch shorter than DEBOUNCE_MS ticks never changes deb.
- Opposing directions:
  - up_eff = deb_up & ~deb_down, and down_eff the mirror of it.
  - left_eff and right_eff are formed the same way.
  - If both of a pair are pressed, both report released.
- Coin FSM, states IDLE / PULSE / WAIT_REL:
  - IDLE: if deb_coin is pressed, go to PULSE, load pcnt = COIN_PULSE_MS, and increment coin_count unless it is 255.
  - PULSE: coin_pulse = 1. On each ms_tick pcnt decrements. On the tick where pcnt reaches 0, go to WAIT_REL.
  - WAIT_REL: coin_pulse = 0. Stay until deb_coin is released, then go to IDLE.
  - Holding coin produces exactly one pulse. Releasing during PULSE does not shorten the pulse.
  - If the button is already released when PULSE ends, WAIT_REL is left on the next cycle.
- Output register:
  - buttons_a and buttons_b are updated every cycle from the effective states and coin_pulse, inverted (active-low).
  - Latency from a deb/coin_pulse change to the port byte is 1 cycle.
  - Constant bits are always 1.
- Start has no coin-style pulse shaping; it is debounced only.
- Reset mid-operation (during PULSE or mid-debounce) aborts immediately to the reset values. coin_count is cleared.

Test Plan (all scenarios use CLK_HZ=10000, i.e. a tick every 10 cycles; DEBOUNCE_MS=3; COIN_PULSE_MS=5):
1. Reset: assert reset_n=0 mid-run → buttons_a=buttons_b=8'hFF and coin_count=0 asynchronously; after release, first ms_tick at cycle 10.
2. Debounce: drive up low steadily → buttons_a goes 8'hFF→8'hFE on the third tick after the synchronised change plus 1 cycle. A low glitch lasting 2 ticks, then high → buttons_a stays 8'hFF.
3. Glitch restart: up low for 2 ticks, high for 1 cycle, then low steadily → the counter restarts and the change appears only after 3 further full ticks.
4. Opposing pair: press up and down together (debounced) → bits 0 and 3 both 1 (buttons_a=8'hFF). Release down → buttons_a=8'hFE.
5. Coin:
   - Hold coin for 50 ticks → bit 5 low for exactly 5 ticks (50 cycles ±1 tick phase), then high while still held; coin_count=1.
   - Release, then press again → a second pulse; coin_count=2.
   - A 1-tick coin tap after 3 debounced ticks gives a full 5-tick pulse.
6. Saturation and start:
   - Issue 257 coin presses → coin_count=255.
   - Press start → buttons_b=8'hDF after debounce; release → 8'hFF.
